mips_load_sequencer: RTL and testbench

- Multi-cycle MIPS control FSM that drives the load strobes of the datapath holding registers: PC, NPC, IR, A, B, Imm, ALUOut, LMD.
- Each strobe is a single-cycle pulse. A register captures on the clock edge that ends the cycle in which its strobe is high.
- Sequences IF/ID/EX/MEM/WB per opcode class and handshakes with instruction/data memory through mem_ready.

---
 rtl/mips_ctrl_pkg.sv | 25 ++
 rtl/mem_wait_timer.sv | 43 ++++
 rtl/mips_load_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mips_load_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the MIPS multi-cycle control path
// Purpose: state encoding, opcode constants and pc_sel encodings used by
//          mips_load_sequencer and its testbench.
// Ports:   none (package).
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic PCSEL_NPC = 1'b0;
  localparam logic PCSEL_ALU = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory wait-cycle counter with timeout compare
// Purpose: counts cycles spent waiting for mem_ready and flags the last
//          allowed wait cycle. LIMIT=0 disables the timeout.
// Ports:   clk, rst (sync, active-high)
//          clear   - state changed this cycle; restart the count
//          waiting - in a memory wait cycle with mem_ready low
//          timeout - this wait cycle is the LIMIT-th one
module mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);

  localparam logic [3:0] LAST = 4'(LIMIT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 4'd0;
    end else if (waiting) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of wait cycles already completed, so the
  // LIMIT-th wait cycle is the one where cnt_q == LIMIT-1.
  assign timeout = (LIMIT != 0) && waiting && (cnt_q == LAST);

endmodule

// File: rtl/mips_load_sequencer.sv
// rtl/mips_load_sequencer.sv - multi-cycle MIPS control FSM driving datapath load strobes
// Purpose: sequences IF/ID/EX/MEM/WB per opcode class, pulses the register
//          load strobes and handshakes with memory through mem_ready.
// Ports:   clk, rst (sync, active-high), run, opcode, branch_taken, mem_ready
//          load_pc/npc/ir/a/b/imm/alu/lmd - single-cycle capture strobes
//          pc_sel, mem_read, mem_write, reg_write, instr_done, illegal_op
//          mem_err (sticky timeout flag), state (debug)
// Optional: LOAD_SEQ_PERF_EN adds cycle_cnt and instr_cnt outputs.
module mips_load_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned OPW         = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           branch_taken,
  input  logic           mem_ready,
  output logic           load_pc,
  output logic           load_npc,
  output logic           load_ir,
  output logic           load_a,
  output logic           load_b,
  output logic           load_imm,
  output logic           load_alu,
  output logic           load_lmd,
  output logic           pc_sel,
  output logic           mem_read,
  output logic           mem_write,
  output logic           reg_write,
  output logic           instr_done,
  output logic           illegal_op,
  output logic           mem_err,
  output logic [2:0]     state
`ifdef LOAD_SEQ_PERF_EN
  ,
  output logic [31:0]    cycle_cnt,
  output logic [31:0]    instr_cnt
`endif
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           mem_err_q, mem_err_d;
  logic           retire;
  logic           waiting;
  logic           timeout;

  // Count only cycles that are genuinely stalled on memory; a cycle with
  // mem_ready high always completes, so it can never time out.
  assign waiting = ((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready;

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .waiting (waiting),
    .timeout (timeout)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mem_err_d  = mem_err_q;
    retire     = 1'b0;
    load_pc    = 1'b0;
    load_npc   = 1'b0;
    load_ir    = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_imm   = 1'b0;
    load_alu   = 1'b0;
    load_lmd   = 1'b0;
    pc_sel     = PCSEL_NPC;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_IF;
      end
      ST_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          load_ir  = 1'b1;
          load_npc = 1'b1;
          state_d  = ST_ID;
        end else if (timeout) begin
          mem_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ID: begin
        load_a   = 1'b1;
        load_b   = 1'b1;
        load_imm = 1'b1;
        op_d     = opcode;
        state_d  = ST_EX;
      end
      ST_EX: begin
        load_alu = 1'b1;
        if (op_q == OPW'(OP_RTYPE)) begin
          state_d = ST_WB;
        end else if ((op_q == OPW'(OP_LW)) || (op_q == OPW'(OP_SW))) begin
          state_d = ST_MEM;
        end else if (op_q == OPW'(OP_BEQ)) begin
          load_pc = 1'b1;
          pc_sel  = branch_taken;
          retire  = 1'b1;
        end else if (op_q == OPW'(OP_J)) begin
          load_pc = 1'b1;
          pc_sel  = PCSEL_ALU;
          retire  = 1'b1;
        end else begin
          // Unknown opcodes are skipped: PC advances to NPC.
          illegal_op = 1'b1;
          load_pc    = 1'b1;
          retire     = 1'b1;
        end
      end
      ST_MEM: begin
        if (op_q == OPW'(OP_LW)) begin
          mem_read = 1'b1;
          if (mem_ready) begin
            load_lmd = 1'b1;
            state_d  = ST_WB;
          end
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            load_pc = 1'b1;
            retire  = 1'b1;
          end
        end
        if (!mem_ready && timeout) begin
          mem_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        load_pc   = 1'b1;
        retire    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // run is only looked at on retirement (and in IDLE above).
    if (retire) state_d = run ? ST_IF : ST_IDLE;
  end

  assign instr_done = retire;
  assign mem_err    = mem_err_q;
  assign state      = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef LOAD_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + ((state_q != ST_IDLE) ? 32'd1 : 32'd0);
    instr_cnt_d = instr_cnt_q + (retire ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mips_load_sequencer.sv
// tb/tb_mips_load_sequencer.sv - self-checking bench for mips_load_sequencer
module tb_mips_load_sequencer;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, run, branch_taken, mem_ready;
  logic [5:0] opcode;
  logic load_pc, load_npc, load_ir, load_a, load_b, load_imm, load_alu, load_lmd;
  logic pc_sel, mem_read, mem_write, reg_write, instr_done, illegal_op, mem_err;
  logic [2:0] state;
`ifdef LOAD_SEQ_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mips_load_sequencer #(.MEM_TIMEOUT(15), .OPW(6)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .load_pc(load_pc), .load_npc(load_npc), .load_ir(load_ir), .load_a(load_a),
    .load_b(load_b), .load_imm(load_imm), .load_alu(load_alu), .load_lmd(load_lmd),
    .pc_sel(pc_sel), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_err(mem_err), .state(state)
`ifdef LOAD_SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected-output bit masks: one bit per observed output.
  localparam logic [14:0] ERR  = 15'h4000;
  localparam logic [14:0] LPC  = 15'h2000;
  localparam logic [14:0] LNPC = 15'h1000;
  localparam logic [14:0] LIR  = 15'h0800;
  localparam logic [14:0] LA   = 15'h0400;
  localparam logic [14:0] LB   = 15'h0200;
  localparam logic [14:0] LIMM = 15'h0100;
  localparam logic [14:0] LALU = 15'h0080;
  localparam logic [14:0] LLMD = 15'h0040;
  localparam logic [14:0] PSEL = 15'h0020;
  localparam logic [14:0] MRD  = 15'h0010;
  localparam logic [14:0] MWR  = 15'h0008;
  localparam logic [14:0] REGW = 15'h0004;
  localparam logic [14:0] DONE = 15'h0002;
  localparam logic [14:0] ILL  = 15'h0001;

  int checks = 0;
  int errors = 0;
  int unsigned model_cycles = 0;
  int unsigned model_instrs = 0;
  logic [14:0] obs;

  // One clock cycle: apply mem_ready, compare at the falling edge, then step.
  task automatic cyc(input logic [2:0] st, input logic [14:0] exp,
                     input logic rdy, input string tag);
    mem_ready = rdy;
    @(negedge clk);
    // pc_sel is don't-care unless load_pc is high.
    obs = {mem_err, load_pc, load_npc, load_ir, load_a, load_b, load_imm, load_alu,
           load_lmd, pc_sel & load_pc, mem_read, mem_write, reg_write, instr_done,
           illegal_op};
    checks++;
    assert (state === st) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, st);
    end
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s outputs: got %h expected %h", tag, obs, exp);
    end
    if (st != 3'd0) model_cycles++;
    if ((exp & DONE) != 15'd0) model_instrs++;
    @(posedge clk);
    #1;
  endtask

  // Reference model for one instruction, entered in IF with run=1.
  task automatic do_instr(input logic [5:0] op, input logic bt, input int dif,
                          input int dmem, input logic drop_run);
    logic [14:0] e;
    for (int k = 0; k <= dif; k++)
      cyc(3'd1, (k == dif) ? (MRD | LIR | LNPC) : MRD, k == dif, "if");
    opcode = op;
    cyc(3'd2, LA | LB | LIMM, 1'($urandom), "id");
    opcode = 6'($urandom);
    if (drop_run) run = 1'b0;
    branch_taken = bt;
    if (op == OP_RTYPE || op == OP_LW || op == OP_SW) e = LALU;
    else if (op == OP_BEQ) e = LALU | LPC | DONE | (bt ? PSEL : 15'd0);
    else if (op == OP_J) e = LALU | LPC | DONE | PSEL;
    else e = LALU | LPC | DONE | ILL;
    cyc(3'd3, e, 1'($urandom), "ex");
    branch_taken = 1'($urandom);
    if (op == OP_LW || op == OP_SW) begin
      for (int k = 0; k <= dmem; k++) begin
        if (op == OP_LW) e = MRD | ((k == dmem) ? LLMD : 15'd0);
        else e = MWR | ((k == dmem) ? (LPC | DONE) : 15'd0);
        cyc(3'd4, e, k == dmem, "mem");
      end
    end
    if (op == OP_RTYPE || op == OP_LW)
      cyc(3'd5, REGW | LPC | DONE, 1'($urandom), "wb");
  endtask

  task automatic check_perf(input string tag);
`ifdef LOAD_SEQ_PERF_EN
    checks++;
    assert (cycle_cnt === model_cycles) else begin
      errors++;
      $error("FAIL %s cycle_cnt: got %0d expected %0d", tag, cycle_cnt, model_cycles);
    end
    checks++;
    assert (instr_cnt === model_instrs) else begin
      errors++;
      $error("FAIL %s instr_cnt: got %0d expected %0d", tag, instr_cnt, model_instrs);
    end
`else
    if (tag.len() == 0) $display("perf counters absent");
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] op;
    int sel;
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 6'd0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(3'd0, 15'd0, 1'b1, "reset");
    rst = 1'b0;
    model_cycles = 0; model_instrs = 0;
    run = 1'b1;
    cyc(3'd0, 15'd0, 1'b1, "idle_exit");

    // Directed: R-type, lw with stalls, beq taken/not taken, illegal opcode.
    do_instr(OP_RTYPE, 1'b0, 0, 0, 1'b0);
    do_instr(OP_LW,    1'b0, 3, 2, 1'b0);
    do_instr(OP_BEQ,   1'b1, 0, 0, 1'b0);
    do_instr(OP_BEQ,   1'b0, 1, 0, 1'b0);
    do_instr(6'b111111, 1'b0, 0, 0, 1'b0);
    do_instr(OP_SW,    1'b0, 2, 3, 1'b0);

    // run dropped mid-instruction: the jump completes, then halt in IDLE.
    do_instr(OP_J, 1'b0, 1, 0, 1'b1);
    cyc(3'd0, 15'd0, 1'b1, "halted");
    run = 1'b1;
    cyc(3'd0, 15'd0, 1'b0, "restart");

    // Randomised instruction stream.
    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        default: begin
          do op = 6'($urandom);
          while (op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J);
        end
      endcase
      do_instr(op, 1'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0);
    end

    // Fetch timeout: 15 stalled IF cycles, then abort to IDLE with mem_err.
    run = 1'b0;
    for (int k = 0; k < 15; k++) cyc(3'd1, MRD, 1'b0, "timeout_wait");
    cyc(3'd0, ERR, 1'b0, "timeout_idle");
    cyc(3'd0, ERR, 1'b1, "err_sticky");
    check_perf("perf_run");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_cycles = 0; model_instrs = 0;
    cyc(3'd0, 15'd0, 1'b0, "err_cleared");

    // Reset during a store's memory wait.
    run = 1'b1;
    cyc(3'd0, 15'd0, 1'b0, "idle_sw");
    cyc(3'd1, MRD | LIR | LNPC, 1'b1, "sw_if");
    opcode = OP_SW;
    cyc(3'd2, LA | LB | LIMM, 1'b0, "sw_id");
    cyc(3'd3, LALU, 1'b0, "sw_ex");
    cyc(3'd4, MWR, 1'b0, "sw_wait");
    rst = 1'b1;
    cyc(3'd4, MWR, 1'b0, "sw_wait_rst");
    rst = 1'b0;
    run = 1'b0;
    model_cycles = 0; model_instrs = 0;
    cyc(3'd0, 15'd0, 1'b1, "after_rst");
    check_perf("perf_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
